sram_sp_8192x32_ctrl: RTL and testbench

Initiator-side controller for the 8192x32 single-port byte-enable SRAM macro (active-low CEN/GWEN/BEN pins, 1-cycle read latency). It accepts core-side req/gnt requests and drives the macro pins. It returns read data through a 3-entry valid/ready response FIFO. After reset it zero-fills the whole array before granting any request, so software sees deterministic memory contents.

---
 rtl/sram_sp_8192x32_ctrl_if.sv | 26 ++
 rtl/sram_sp_8192x32_ctrl.sv | 113 +++++++++++
 tb/tb_sram_sp_8192x32_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_sp_8192x32_ctrl_if.sv
// Core-side request/response bus of the single-port SRAM controller.
// master = requesting core, slave = controller.
interface sram_sp_8192x32_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    req_i;
    logic                    gnt_o;
    logic                    we_i;
    logic [DATA_WIDTH/8-1:0] be_i;
    logic [ADDR_WIDTH-1:0]   addr_i;
    logic [DATA_WIDTH-1:0]   wdata_i;
    logic                    rvalid_o;
    logic [DATA_WIDTH-1:0]   rdata_o;
    logic                    rready_i;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i, rready_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i, rready_i,
        output gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/sram_sp_8192x32_ctrl.sv
// Controller for a single-port byte-enable SRAM macro: zero-fills the array after reset,
// then serves req/gnt accesses and returns read data through a 3-entry response FIFO.
module sram_sp_8192x32_ctrl #(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          INIT_ZERO  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    sram_sp_8192x32_ctrl_if.slave   bus,
    output logic                    init_done_o,
    output logic                    CEN,
    output logic                    GWEN,
    output logic [DATA_WIDTH/8-1:0] BEN,
    output logic [ADDR_WIDTH-1:0]   A,
    output logic [DATA_WIDTH-1:0]   D,
    input  logic [DATA_WIDTH-1:0]   Q
);
    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   init_addr_q;
    logic                    init_done_q;
    logic                    pending_q;
    logic [1:0]              count_q;
    logic [1:0]              wptr_q;
    logic [1:0]              rptr_q;
    logic [DATA_WIDTH-1:0]   hold_q;
    logic [DATA_WIDTH-1:0]   fifo_mem [3];

    logic       gnt;
    logic       rd_acc;
    logic       push;
    logic       pop;
    logic       rvalid;
    logic [1:0] occ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StInit;
            init_addr_q <= '0;
            init_done_q <= 1'b0;
        end else if (state_q == StInit) begin
            if (!INIT_ZERO || init_addr_q == '1) begin
                state_q     <= StRun;
                init_done_q <= 1'b1;
            end else begin
                init_addr_q <= init_addr_q + 1'b1;
            end
        end
    end

    // Reads in flight (pending) plus buffered responses must never exceed the FIFO depth.
    assign rvalid = (count_q != 2'd0);
    assign occ    = count_q + {1'b0, pending_q};
    assign gnt    = (state_q == StRun) && bus.req_i && (bus.we_i || occ != 2'd3);
    assign rd_acc = gnt && !bus.we_i;
    assign push   = pending_q;
    assign pop    = rvalid && bus.rready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= 1'b0;
            count_q   <= 2'd0;
            wptr_q    <= 2'd0;
            rptr_q    <= 2'd0;
            hold_q    <= '0;
        end else begin
            pending_q <= rd_acc;
            count_q   <= count_q + {1'b0, push} - {1'b0, pop};
            if (push) wptr_q <= (wptr_q == 2'd2) ? 2'd0 : wptr_q + 2'd1;
            if (pop) begin
                rptr_q <= (rptr_q == 2'd2) ? 2'd0 : rptr_q + 2'd1;
                hold_q <= fifo_mem[rptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr_q] <= Q;
    end

    assign bus.gnt_o    = gnt;
    assign bus.rvalid_o = rvalid;
    assign bus.rdata_o  = rvalid ? fifo_mem[rptr_q] : hold_q;
    assign init_done_o  = init_done_q;

    always_comb begin
        CEN  = 1'b1;
        GWEN = 1'b1;
        BEN  = '1;
        A    = '0;
        D    = '0;
        if (!rst) begin
            if (state_q == StInit) begin
                if (INIT_ZERO) begin
                    CEN  = 1'b0;
                    GWEN = 1'b0;
                    BEN  = '0;
                    A    = init_addr_q;
                end
            end else if (gnt) begin
                CEN = 1'b0;
                A   = bus.addr_i;
                if (bus.we_i) begin
                    GWEN = 1'b0;
                    BEN  = ~bus.be_i;
                    D    = bus.wdata_i;
                end
            end
        end
    end
endmodule

// File: tb/tb_sram_sp_8192x32_ctrl.sv
// Bench for sram_sp_8192x32_ctrl: macro model plus a transaction-level reference
// (expected memory image and an ordered queue of expected read responses).
module tb_sram_sp_8192x32_ctrl;
    localparam int NW = 8192;

    typedef struct {
        logic [31:0] data;
        int          rdy;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_done_o;
    logic        CEN, GWEN;
    logic [3:0]  BEN;
    logic [12:0] A;
    logic [31:0] D, Q;
    logic [31:0] q_r;
    logic [50:0] pins;

    logic [31:0] macro_mem [NW];
    logic [31:0] ref_mem [NW];
    resp_t       exp_q [$];
    logic [31:0] got [$];
    logic [31:0] last_pop;
    bit          run_m;
    int          cyc;
    int          n_cmp, n_fail;
    int          ri, ng, sg, sv;
    bit          g, v;
    logic [31:0] d;

    localparam logic [50:0] IdlePins = {1'b1, 1'b1, 4'hF, 13'h0, 32'h0};

    always #5 clk = ~clk;

    sram_sp_8192x32_ctrl_if bus ();

    sram_sp_8192x32_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .init_done_o (init_done_o),
        .CEN         (CEN),
        .GWEN        (GWEN),
        .BEN         (BEN),
        .A           (A),
        .D           (D),
        .Q           (Q)
    );

    assign Q    = q_r;
    assign pins = {CEN, GWEN, BEN, A, D};

    // Macro model: starts with garbage so an incomplete fill shows up on reads.
    initial begin
        logic [31:0] w;
        for (int i = 0; i < NW; i++) macro_mem[i] = $urandom;
        q_r = '0;
        forever begin
            @(posedge clk);
            if (CEN === 1'b0) begin
                if (GWEN === 1'b0) begin
                    w = macro_mem[A];
                    for (int b = 0; b < 4; b++) begin
                        if (BEN[b] === 1'b0) w[8*b +: 8] = D[8*b +: 8];
                    end
                    macro_mem[A] <= w;
                end else begin
                    q_r <= macro_mem[A];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // One bus cycle, entered and left at posedge+1; checks every observable output.
    task automatic cycle(input bit req, input bit we, input logic [3:0] be,
                         input logic [12:0] addr, input logic [31:0] wd, input bit rready,
                         output bit og, output bit ov, output logic [31:0] od);
        bit          eg, ev;
        logic [31:0] er;
        logic [50:0] ep;
        bus.req_i = req; bus.we_i = we; bus.be_i = be;
        bus.addr_i = addr; bus.wdata_i = wd; bus.rready_i = rready;
        #4;
        eg = run_m && req && (we || exp_q.size() <= 2);
        ev = (exp_q.size() > 0) && (exp_q[0].rdy <= cyc);
        er = ev ? exp_q[0].data : last_pop;
        if (eg && we)  ep = {1'b0, 1'b0, ~be, addr, wd};
        else if (eg)   ep = {1'b0, 1'b1, 4'hF, addr, 32'h0};
        else           ep = IdlePins;
        og = bus.gnt_o; ov = bus.rvalid_o; od = bus.rdata_o;
        chk("gnt", 64'(bus.gnt_o), 64'(eg));
        chk("rvalid", 64'(bus.rvalid_o), 64'(ev));
        chk("rdata", 64'(bus.rdata_o), 64'(er));
        chk("pins", 64'(pins), 64'(ep));
        chk("init_done", 64'(init_done_o), 64'(run_m));
        @(posedge clk);
        if (ev && rready) begin
            last_pop = exp_q[0].data;
            void'(exp_q.pop_front());
        end
        if (eg && we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ref_mem[addr][8*b +: 8] = wd[8*b +: 8];
            end
        end else if (eg) begin
            exp_q.push_back('{data: ref_mem[addr], rdy: cyc + 2});
        end
        cyc++;
        #1;
    endtask

    task automatic idle(output bit ov, output logic [31:0] od);
        bit og;
        cycle(1'b0, 1'b0, 4'h0, 13'h0, 32'h0, 1'b1, og, ov, od);
    endtask

    // Reset, then follow the fill; abort_at >= 0 re-asserts rst at that fill address.
    task automatic reset_fill(input int abort_at);
        rst = 1'b1;
        bus.req_i = 1'b1; bus.we_i = 1'b1; bus.be_i = 4'hF;
        bus.addr_i = 13'($urandom); bus.wdata_i = $urandom; bus.rready_i = 1'b1;
        run_m = 1'b0; exp_q.delete(); last_pop = '0;
        @(posedge clk); #4;
        chk("rst_outputs", 64'({bus.gnt_o, bus.rvalid_o, init_done_o, bus.rdata_o}), 64'h0);
        chk("rst_pins", 64'(pins), 64'(IdlePins));
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < NW; k++) begin
            bus.req_i = 1'($urandom_range(0, 1));
            bus.we_i = 1'($urandom_range(0, 1));
            bus.addr_i = 13'($urandom);
            #4;
            chk("fill_pins", 64'(pins), 64'({1'b0, 1'b0, 4'h0, 13'(k), 32'h0}));
            chk("fill_flags", 64'({bus.gnt_o, init_done_o, bus.rvalid_o}), 64'h0);
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_pins", 64'(pins), 64'(IdlePins));
                chk("abort_gnt", 64'(bus.gnt_o), 64'h0);
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        bus.req_i = 1'b0;
        #4;
        chk("init_done_rise", 64'(init_done_o), 64'h1);
        @(posedge clk); #1;
        for (int i = 0; i < NW; i++) ref_mem[i] = '0;
        run_m = 1'b1;
        cyc = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) idle(v, d);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; cyc = 0;
        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.be_i = 4'h0;
        bus.addr_i = '0; bus.wdata_i = '0; bus.rready_i = 1'b1;

        reset_fill(-1);

        // Zero-filled contents
        cycle(1'b1, 1'b0, 4'h0, 13'h1ABC, 32'h0, 1'b1, g, v, d);
        idle(v, d);
        idle(v, d);
        chk("fill_rd_valid", 64'(v), 64'h1);
        chk("fill_rd_data", 64'(d), 64'h0);

        // Write then immediate read of the same word
        cycle(1'b1, 1'b1, 4'hF, 13'h0010, 32'hDEADBEEF, 1'b1, g, v, d);
        cycle(1'b1, 1'b0, 4'h0, 13'h0010, 32'h0, 1'b1, g, v, d);
        idle(v, d);
        chk("basic_early_valid", 64'(v), 64'h0);
        idle(v, d);
        chk("basic_valid", 64'(v), 64'h1);
        chk("basic_data", 64'(d), 64'hDEADBEEF);

        // Byte lane 1 only, then an all-disabled write that must leave the word alone
        cycle(1'b1, 1'b1, 4'b0010, 13'h0010, 32'h00005500, 1'b1, g, v, d);
        cycle(1'b1, 1'b1, 4'b0000, 13'h0010, 32'hFFFFFFFF, 1'b1, g, v, d);
        cycle(1'b1, 1'b0, 4'h0, 13'h0010, 32'h0, 1'b1, g, v, d);
        idle(v, d);
        idle(v, d);
        chk("be_data", 64'(d), 64'hDEAD55EF);
        idle(v, d);
        chk("rdata_hold", 64'(bus.rdata_o), 64'hDEAD55EF);

        // Backpressure: only three reads fit while the consumer stalls
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 1'b1, 4'hF, 13'(i), 32'(i + 1), 1'b1, g, v, d);
        ri = 0; ng = 0; got.delete();
        for (int t = 0; t < 6; t++) begin
            cycle(1'b1, 1'b0, 4'h0, 13'(ri), 32'h0, 1'b0, g, v, d);
            if (g) begin ng++; ri++; end
        end
        chk("bp_grants", 64'(ng), 64'h3);
        for (int t = 0; t < 20 && (ri < 5 || got.size() < 5); t++) begin
            cycle(ri < 5, 1'b0, 4'h0, 13'(ri), 32'h0, 1'b1, g, v, d);
            if (g && ri < 5) ri++;
            if (v) got.push_back(d);
        end
        for (int j = 0; j < 5; j++) chk("bp_order", 64'(got[j]), 64'(j + 1));
        drain();

        // Streaming reads at full rate
        sg = 0; sv = 0;
        for (int i = 0; i < 18; i++) begin
            cycle(i < 16, 1'b0, 4'h0, 13'($urandom), 32'h0, 1'b1, g, v, d);
            if (i < 16 && g) sg++;
            if (i >= 2 && v) sv++;
        end
        chk("stream_gnt", 64'(sg), 64'd16);
        chk("stream_rvalid", 64'(sv), 64'd16);
        drain();

        // Random mix on a small address window
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom),
                  13'($urandom_range(0, 15)), $urandom, $urandom_range(0, 2) != 0, g, v, d);
        drain();

        // Reset in the middle of the fill, then a full fill again
        reset_fill(100);
        reset_fill(-1);

        // Reset with two reads in flight discards their responses
        cycle(1'b1, 1'b0, 4'h0, 13'h3, 32'h0, 1'b0, g, v, d);
        cycle(1'b1, 1'b0, 4'h0, 13'h4, 32'h0, 1'b0, g, v, d);
        rst = 1'b1;
        #1;
        chk("inflight_rvalid", 64'(bus.rvalid_o), 64'h0);
        chk("inflight_pins", 64'(pins), 64'(IdlePins));
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #4;
            chk("inflight_after", 64'({bus.rvalid_o, bus.rdata_o}), 64'h0);
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
